// File: rtl/pixel_prefetch.sv
// pixel_prefetch: raster-order read prefetcher feeding a show-ahead pixel FIFO for VGA scan-out.
module pixel_prefetch #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int H_VIS = 640,
   parameter int V_VIS = 480
) (
   input  logic        vclk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        pix_rd,
   output logic [2:0]  pix_data,
   output logic        pix_avail,
   output logic        underflow,
   output logic        busy,
   output logic        rd_req,
   output logic [18:0] rd_addr,
   input  logic        rd_gnt,
   input  logic        rd_valid,
   input  logic [2:0]  rd_data
);
   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
   localparam logic [9:0] X_LAST = 10'(H_VIS - 1);
   localparam logic [8:0] Y_LAST = 9'(V_VIS - 1);
   state_t r_state, w_state_n;
   logic [AW:0] r_count, r_pending, r_drop;
   logic [AW:0] w_count_n, w_pending_n, w_drop_n, w_out, w_out_n;
   logic [AW-1:0] r_wp, r_rp;
   logic [2:0] r_mem [DEPTH];
   logic [18:0] r_addr, w_addr_n;
   logic r_req, r_under, w_req_n, w_under_n, w_gnt, w_last, w_pop, w_wr;
   logic [9:0] w_x;
   logic [8:0] w_y;
   // r_pending counts granted-but-unreturned reads plus the presented request
   always_comb begin
      w_x = r_addr[9:0];
      w_y = r_addr[18:10];
      w_gnt = r_req && rd_gnt;
      w_last = w_gnt && w_x == X_LAST && w_y == Y_LAST;
      w_pop = pix_rd && r_count != '0;
      w_wr = rd_valid && r_drop == '0 && !frame_start;
      w_out = r_pending - (AW+1)'(r_req);
      w_out_n = w_out + (AW+1)'(w_gnt) - (AW+1)'(rd_valid);
      w_count_n = frame_start ? '0 : r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      w_drop_n = frame_start ? w_out_n : r_drop - (AW+1)'(rd_valid && r_drop != '0);
      w_under_n = frame_start ? 1'b0 : r_under || (pix_rd && r_count == '0);
      w_state_n = frame_start ? FETCH : (w_last ? DONE : r_state);
      w_addr_n = frame_start ? '0 :
                 (w_gnt && !w_last) ? (w_x == X_LAST ? {w_y + 9'd1, 10'd0} : {w_y, w_x + 10'd1}) :
                 r_addr;
      w_req_n = w_state_n == FETCH &&
                ((!frame_start && r_req && !rd_gnt) || (int'(w_count_n) + int'(w_out_n) < DEPTH));
      w_pending_n = w_out_n + (AW+1)'(w_req_n);
   end
   always_ff @(posedge vclk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_count <= '0;
         r_pending <= '0;
         r_drop <= '0;
         r_wp <= '0;
         r_rp <= '0;
         r_addr <= '0;
         r_req <= 1'b0;
         r_under <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_count <= w_count_n;
         r_pending <= w_pending_n;
         r_drop <= w_drop_n;
         r_wp <= frame_start ? '0 : r_wp + AW'(w_wr);
         r_rp <= frame_start ? '0 : r_rp + AW'(w_pop);
         r_addr <= w_addr_n;
         r_req <= w_req_n;
         r_under <= w_under_n;
      end
   end
   always_ff @(posedge vclk) begin
      if (w_wr) r_mem[r_wp] <= rd_data;
   end
   assign pix_avail = r_count != '0;
   assign pix_data = pix_avail ? r_mem[r_rp] : 3'd0;
   assign underflow = r_under;
   assign busy = r_state == FETCH;
   assign rd_req = r_req;
   assign rd_addr = r_addr;
endmodule
